forwarding_hazard_ctrl: RTL and testbench

FORWARDING_HAZARD_CTRL -- requirements
Module: forwarding_hazard_ctrl

---
 rtl/forwarding_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_forwarding_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// forwarding_hazard_ctrl
//
// Hazard detection and operand-forwarding control for a classic 5-stage
// pipeline. A small shadow pipe mirrors the destination, write-enable and
// load flags of the instructions in EX, MEM and WB. The shadow pipe decides:
//   - the registered forwarding selects for the instruction entering EX,
//   - load-use stalls, which hold PC and IF/ID and bubble ID/EX for one cycle,
//   - the two-slot kill that follows a taken branch (BranchTaken cycle plus
//     one FLUSH cycle).
//
// Optional feature: define HAZARD_STATS_EN to add saturating stall/flush
// counters. Without the macro no counter logic or counter ports exist.
//
// Parameters
//   REG_ADDR_W          register-address width
//   CNT_W               statistics counter width (HAZARD_STATS_EN only)
//
// Ports
//   clk                 clock, rising edge
//   rst_n               asynchronous active-low reset
//   IdValid             IF/ID holds a real instruction
//   IfIdRs, IfIdRt      source registers of the ID instruction
//   IdUsesRt            ID instruction reads Rt
//   IdDest              ID destination register (already Rt/Rd selected)
//   IdWriteRegEnable    ID instruction writes the register file
//   IdReadMemoryEnable  ID instruction is a load
//   BranchTaken         a branch resolved taken this cycle
//   ForwardingMux1Ctrl  registered Rs operand select (00 RF, 01 EX/MEM, 10 WB)
//   ForwardingMux2Ctrl  registered Rt operand select (same encoding)
//   Stall               combinational: hold PC and IF/ID
//   BubbleInsert        combinational: zero ID/EX control on this edge
//   Flush               registered: discard IF/ID contents
//   StallCount          (HAZARD_STATS_EN) saturating count of stall cycles
//   FlushCount          (HAZARD_STATS_EN) saturating count of RUN->FLUSH moves
// ---------------------------------------------------------------------------
module forwarding_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  IdValid,
    input  logic [REG_ADDR_W-1:0] IfIdRs,
    input  logic [REG_ADDR_W-1:0] IfIdRt,
    input  logic                  IdUsesRt,
    input  logic [REG_ADDR_W-1:0] IdDest,
    input  logic                  IdWriteRegEnable,
    input  logic                  IdReadMemoryEnable,
    input  logic                  BranchTaken,
    output logic [1:0]            ForwardingMux1Ctrl,
    output logic [1:0]            ForwardingMux2Ctrl,
    output logic                  Stall,
    output logic                  BubbleInsert,
    output logic                  Flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount
`endif
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [0:0]            state;
    logic [0:0]            state_next;

    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_we;
    logic                  ex_memread;

    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_we;
    logic                  mem_memread;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  wb_we;
    logic                  wb_memread;

    logic [1:0]            fwd1_next;
    logic [1:0]            fwd2_next;

    // ---------------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------------
    logic ex_dest_nz;
    logic mem_dest_nz;
    logic load_use;
    logic in_flush;

    assign ex_dest_nz  = (ex_dest != '0);
    assign mem_dest_nz = (mem_dest != '0);
    assign in_flush    = (state == FLUSH);

    // Register 0 is never a real producer, hence the non-zero qualifiers.
    assign load_use = IdValid && ex_valid && ex_memread && ex_dest_nz &&
                      ((ex_dest == IfIdRs) || (IdUsesRt && (ex_dest == IfIdRt)));

    // A taken branch or FLUSH kills the ID instruction anyway, so a stall
    // there would only waste a cycle.
    assign Stall        = load_use && (state == RUN) && !BranchTaken;
    assign BubbleInsert = Stall || BranchTaken || in_flush || !IdValid;
    assign Flush        = in_flush;

    // ---------------------------------------------------------------------
    // Forwarding select for the instruction about to enter EX.
    // EX holds the youngest producer, so it wins over MEM.
    // ---------------------------------------------------------------------
    logic ex_hit_rs;
    logic ex_hit_rt;
    logic mem_hit_rs;
    logic mem_hit_rt;

    assign ex_hit_rs  = ex_we  && ex_dest_nz  && (ex_dest  == IfIdRs);
    assign ex_hit_rt  = ex_we  && ex_dest_nz  && (ex_dest  == IfIdRt);
    assign mem_hit_rs = mem_we && mem_dest_nz && (mem_dest == IfIdRs);
    assign mem_hit_rt = mem_we && mem_dest_nz && (mem_dest == IfIdRt);

    always_comb begin
        fwd1_next = FWD_RF;
        fwd2_next = FWD_RF;
        if (!BubbleInsert) begin
            if (ex_hit_rs) begin
                fwd1_next = FWD_EX;
            end else if (mem_hit_rs) begin
                fwd1_next = FWD_WB;
            end

            if (IdUsesRt) begin
                if (ex_hit_rt) begin
                    fwd2_next = FWD_EX;
                end else if (mem_hit_rt) begin
                    fwd2_next = FWD_WB;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Branch flush FSM: one FLUSH cycle after every taken branch in RUN.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (BranchTaken) state_next = FLUSH;
            FLUSH:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Shadow pipe and registered forwarding selects
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid           <= 1'b0;
            ex_dest            <= '0;
            ex_we              <= 1'b0;
            ex_memread         <= 1'b0;
            mem_valid          <= 1'b0;
            mem_dest           <= '0;
            mem_we             <= 1'b0;
            mem_memread        <= 1'b0;
            wb_valid           <= 1'b0;
            wb_dest            <= '0;
            wb_we              <= 1'b0;
            wb_memread         <= 1'b0;
            ForwardingMux1Ctrl <= FWD_RF;
            ForwardingMux2Ctrl <= FWD_RF;
        end else begin
            wb_valid    <= mem_valid;
            wb_dest     <= mem_dest;
            wb_we       <= mem_we;
            wb_memread  <= mem_memread;

            mem_valid   <= ex_valid;
            mem_dest    <= ex_dest;
            mem_we      <= ex_we;
            mem_memread <= ex_memread;

            if (BubbleInsert) begin
                ex_valid   <= 1'b0;
                ex_dest    <= '0;
                ex_we      <= 1'b0;
                ex_memread <= 1'b0;
            end else begin
                ex_valid   <= IdValid;
                ex_dest    <= IdDest;
                ex_we      <= IdWriteRegEnable;
                ex_memread <= IdReadMemoryEnable;
            end

            ForwardingMux1Ctrl <= fwd1_next;
            ForwardingMux2Ctrl <= fwd2_next;
        end
    end

    // A bubble slot carries all-zero fields all the way to WB.
    wb_bubble_clean: assert property (@(posedge clk) disable iff (!rst_n)
        !wb_valid |-> (wb_dest == '0 && !wb_we && !wb_memread));

`ifdef HAZARD_STATS_EN
    // ---------------------------------------------------------------------
    // Saturating statistics counters
    // ---------------------------------------------------------------------
    logic flush_start;

    assign flush_start = (state == RUN) && BranchTaken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (Stall && (StallCount != '1)) begin
                StallCount <= StallCount + 1'b1;
            end
            if (flush_start && (FlushCount != '1)) begin
                FlushCount <= FlushCount + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_forwarding_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_forwarding_hazard_ctrl
//
// Scoreboard bench. The stimulus process drives one ID-stage instruction per
// cycle (directed scenarios, then random ones with occasional resets), works
// out the expected response from a pipeline model and queues it. A separate
// monitor pops one entry per cycle, just before the rising edge, and compares
// it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_forwarding_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          IdValid;
    logic [AW-1:0] IfIdRs;
    logic [AW-1:0] IfIdRt;
    logic          IdUsesRt;
    logic [AW-1:0] IdDest;
    logic          IdWriteRegEnable;
    logic          IdReadMemoryEnable;
    logic          BranchTaken;
    logic [1:0]    ForwardingMux1Ctrl;
    logic [1:0]    ForwardingMux2Ctrl;
    logic          Stall;
    logic          BubbleInsert;
    logic          Flush;
`ifdef HAZARD_STATS_EN
    logic [CW-1:0] StallCount;
    logic [CW-1:0] FlushCount;
`endif

    forwarding_hazard_ctrl #(
        .REG_ADDR_W(AW),
        .CNT_W     (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .IdValid           (IdValid),
        .IfIdRs            (IfIdRs),
        .IfIdRt            (IfIdRt),
        .IdUsesRt          (IdUsesRt),
        .IdDest            (IdDest),
        .IdWriteRegEnable  (IdWriteRegEnable),
        .IdReadMemoryEnable(IdReadMemoryEnable),
        .BranchTaken       (BranchTaken),
        .ForwardingMux1Ctrl(ForwardingMux1Ctrl),
        .ForwardingMux2Ctrl(ForwardingMux2Ctrl),
        .Stall             (Stall),
        .BubbleInsert      (BubbleInsert),
        .Flush             (Flush)
`ifdef HAZARD_STATS_EN
        ,
        .StallCount        (StallCount),
        .FlushCount        (FlushCount)
`endif
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model: list of in-flight instructions, youngest first.
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic          v;
        logic [AW-1:0] d;
        logic          we;
        logic          mr;
    } ent_t;

    typedef struct packed {
        logic          stall;
        logic          bubble;
        logic [1:0]    f1;
        logic [1:0]    f2;
        logic          flush;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    ent_t          pipe [3];       // 0 = EX, 1 = MEM, 2 = WB
    logic          m_flush;        // one killed slot still owed after a branch
    logic [1:0]    m_f1;
    logic [1:0]    m_f2;
    logic [CW-1:0] m_sc;
    logic [CW-1:0] m_fc;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_flush = 1'b0;
        m_f1    = 2'b00;
        m_f2    = 2'b00;
        m_sc    = '0;
        m_fc    = '0;
    endfunction

    // Nearest older writer of src: EX gives 01, MEM gives 10, none gives 00.
    function automatic logic [1:0] fwd(input logic [AW-1:0] src);
        for (int s = 0; s < 2; s++) begin
            if (pipe[s].we && pipe[s].d != 0 && pipe[s].d == src)
                return (s == 0) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One cycle of stimulus: drive at the falling edge, queue expectation,
    // advance the model to the state after the next rising edge.
    task automatic step(input bit rst, input logic v, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic u, input logic [AW-1:0] d,
                        input logic we, input logic mr, input logic br);
        exp_t       e;
        logic       lu;
        logic       st;
        logic       bub;
        logic [1:0] n1;
        logic [1:0] n2;
        @(negedge clk);
        rst_n              = !rst;
        IdValid            = v;
        IfIdRs             = rs;
        IfIdRt             = rt;
        IdUsesRt           = u;
        IdDest             = d;
        IdWriteRegEnable   = we;
        IdReadMemoryEnable = mr;
        BranchTaken        = br;
        if (rst) model_reset();

        lu  = v && pipe[0].v && pipe[0].mr && pipe[0].d != 0 &&
              (pipe[0].d == rs || (u && pipe[0].d == rt));
        st  = lu && !m_flush && !br;
        bub = st || br || m_flush || !v;

        e.stall  = st;
        e.bubble = bub;
        e.f1     = m_f1;
        e.f2     = m_f2;
        e.flush  = m_flush;
        e.sc     = m_sc;
        e.fc     = m_fc;
        q.push_back(e);

        if (!rst) begin
            n1 = bub ? 2'b00 : fwd(rs);
            n2 = (bub || !u) ? 2'b00 : fwd(rt);
            if (st && m_sc != '1) m_sc = m_sc + 1'b1;
            if (br && !m_flush && m_fc != '1) m_fc = m_fc + 1'b1;
            m_flush = br && !m_flush;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = bub ? ent_t'('0) : ent_t'{1'b1, d, we, mr};
            m_f1    = n1;
            m_f2    = n2;
        end
    endtask

    // ---------------------------------------------------------------------
    // Monitor: sample one rising-edge-minus-1 snapshot per queued entry.
    // ---------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("stall",  32'(Stall),              32'(e.stall));
                check("bubble", 32'(BubbleInsert),       32'(e.bubble));
                check("fwd1",   32'(ForwardingMux1Ctrl), 32'(e.f1));
                check("fwd2",   32'(ForwardingMux2Ctrl), 32'(e.f2));
                check("flush",  32'(Flush),              32'(e.flush));
`ifdef HAZARD_STATS_EN
                check("stall_count", 32'(StallCount), 32'(e.sc));
                check("flush_count", 32'(FlushCount), 32'(e.fc));
`endif
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        rst_n              = 1'b0;
        IdValid            = 1'b0;
        IfIdRs             = '0;
        IfIdRt             = '0;
        IdUsesRt           = 1'b0;
        IdDest             = '0;
        IdWriteRegEnable   = 1'b0;
        IdReadMemoryEnable = 1'b0;
        BranchTaken        = 1'b0;
        model_reset();

        // Reset, then the first cycle after release.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 8, 3, 1, 9, 1, 0, 0);
        step(0, 1, 8, 3, 1, 9, 1, 0, 0);

        // lw $8 followed by add $9,$8,$3: one stall, then WB forward on Rs.
        step(0, 1, 1, 2, 0, 8, 1, 1, 0);
        step(0, 1, 8, 3, 1, 9, 1, 0, 0);
        step(0, 1, 8, 3, 1, 9, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // add $5 then sub reading Rt=$5: no stall, EX forward on Rt.
        step(0, 1, 1, 2, 1, 5, 1, 0, 0);
        step(0, 1, 4, 5, 1, 6, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // $7 produced by MEM and EX entries: EX wins.
        step(0, 1, 1, 2, 1, 7, 1, 0, 0);
        step(0, 1, 1, 2, 1, 7, 1, 0, 0);
        step(0, 1, 7, 2, 0, 3, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Taken branch with a load-use pending: no stall, two killed slots.
        step(0, 1, 1, 2, 0, 4, 1, 1, 0);
        step(0, 1, 4, 2, 1, 5, 1, 0, 1);
        step(0, 1, 4, 2, 1, 5, 1, 0, 1);
        step(0, 1, 4, 2, 1, 5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // $0 destination with a write (and as a load): never forwarded, no stall.
        step(0, 1, 1, 2, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 1, 3, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a FLUSH and in the middle of a stall.
        step(0, 1, 1, 1, 1, 2, 1, 0, 1);
        step(1, 1, 1, 1, 1, 2, 1, 0, 0);
        step(0, 1, 1, 1, 1, 2, 1, 0, 0);
        step(0, 1, 1, 1, 0, 3, 1, 1, 0);
        step(0, 1, 3, 1, 1, 4, 1, 0, 0);
        step(1, 1, 3, 1, 1, 4, 1, 0, 0);
        step(0, 1, 3, 1, 1, 4, 1, 0, 0);

        // Randomized traffic on a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            rst = ($urandom_range(0, 199) == 0);
            step(rst,
                 ($urandom_range(0, 9) < 9),
                 AW'($urandom_range(0, 3)),
                 AW'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) == 0));
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #6;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Safety net: the run is bounded by the loop above; this only guards hangs.
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
